// File: rtl/aclk_pkg.sv
// Shared alarm-clock time-base constants, used by the tick generator and the
// time/alarm counters.
package aclk_pkg;

    localparam int ACLK_CLK_PER_SEC  = 256;
    localparam int ACLK_SEC_PER_MIN  = 60;
    localparam int ACLK_MIN_PER_HOUR = 60;

endpackage

// File: rtl/aclk_tickgen_if.sv
// Control and status bundle of the tick generator: run/clear/stopwatch inputs,
// one-cycle tick pulses and the running seconds/minutes counts.
interface aclk_tickgen_if
    import aclk_pkg::*;
#(
    parameter int SW = $clog2(ACLK_SEC_PER_MIN),
    parameter int MW = $clog2(ACLK_MIN_PER_HOUR)
);

    logic          reset_count;
    logic          run;
    logic          stop_watch;
    logic          one_second;
    logic          one_minute;
    logic          one_hour;
    logic [SW-1:0] sec_count;
    logic [MW-1:0] min_count;

    modport master (
        output reset_count, run, stop_watch,
        input  one_second, one_minute, one_hour, sec_count, min_count
    );

    modport slave (
        input  reset_count, run, stop_watch,
        output one_second, one_minute, one_hour, sec_count, min_count
    );

endinterface

// File: rtl/aclk_modcounter.sv
// Modulo-N up counter with synchronous clear; wrap flags the increment that
// takes the count from N-1 back to 0.
module aclk_modcounter
    import aclk_pkg::*;
#(
    parameter  int N = ACLK_SEC_PER_MIN,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_top;

    assign at_top = (count_q == W'(N - 1));
    assign wrap   = inc && at_top;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = at_top ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aclk_tickgen.sv
// Alarm-clock time base: prescaler -> seconds -> minutes chain producing
// registered one-cycle second/minute/hour pulses and the running counts.
module aclk_tickgen
    import aclk_pkg::*;
#(
    parameter int CLK_PER_SEC  = ACLK_CLK_PER_SEC,
    parameter int SEC_PER_MIN  = ACLK_SEC_PER_MIN,
    parameter int MIN_PER_HOUR = ACLK_MIN_PER_HOUR
) (
    input  logic           clk,
    input  logic           reset,
    aclk_tickgen_if.slave  bus
);

    localparam int PW = $clog2(CLK_PER_SEC);
    localparam int SW = $clog2(SEC_PER_MIN);
    localparam int MW = $clog2(MIN_PER_HOUR);

    if (CLK_PER_SEC < 2 || SEC_PER_MIN < 2 || MIN_PER_HOUR < 2) begin : g_param_check
        $error("aclk_tickgen: CLK_PER_SEC, SEC_PER_MIN and MIN_PER_HOUR must all be >= 2");
    end

    logic [PW-1:0] p_count;
    logic          p_wrap;
    logic [SW-1:0] sec_count;
    logic          sec_wrap;
    logic [MW-1:0] min_count;
    logic          min_wrap;
    logic          min_inc;

    logic one_second_q, one_second_d;
    logic one_minute_q, one_minute_d;
    logic one_hour_q,   one_hour_d;

    // Prescaler only advances under run, so a pause freezes the whole chain
    // and keeps the residual fraction of the current second.
    aclk_modcounter #(.N(CLK_PER_SEC)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.reset_count),
        .inc   (bus.run),
        .count (p_count),
        .wrap  (p_wrap)
    );

    aclk_modcounter #(.N(SEC_PER_MIN)) u_seconds (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.reset_count),
        .inc   (p_wrap),
        .count (sec_count),
        .wrap  (sec_wrap)
    );

    // In stopwatch mode every second event is also a minute event.
    assign min_inc = sec_wrap || (p_wrap && bus.stop_watch);

    aclk_modcounter #(.N(MIN_PER_HOUR)) u_minutes (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.reset_count),
        .inc   (min_inc),
        .count (min_count),
        .wrap  (min_wrap)
    );

    always_comb begin
        one_second_d = p_wrap;
        one_minute_d = min_inc;
        one_hour_d   = min_wrap;
        if (bus.reset_count) begin
            one_second_d = 1'b0;
            one_minute_d = 1'b0;
            one_hour_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            one_second_q <= 1'b0;
            one_minute_q <= 1'b0;
            one_hour_q   <= 1'b0;
        end else begin
            one_second_q <= one_second_d;
            one_minute_q <= one_minute_d;
            one_hour_q   <= one_hour_d;
        end
    end

    assign bus.one_second = one_second_q;
    assign bus.one_minute = one_minute_q;
    assign bus.one_hour   = one_hour_q;
    assign bus.sec_count  = sec_count;
    assign bus.min_count  = min_count;

    a_p_range: assert property (@(posedge clk) disable iff (reset)
        32'(p_count) < CLK_PER_SEC);
    a_sec_range: assert property (@(posedge clk) disable iff (reset)
        32'(sec_count) < SEC_PER_MIN);
    a_min_range: assert property (@(posedge clk) disable iff (reset)
        32'(min_count) < MIN_PER_HOUR);

endmodule

// File: doc/aclk_tickgen.md
# aclk_tickgen

Parametrised time-base generator for the alarm clock: divides the system clock into one-cycle `one_second`, `one_minute` and `one_hour` pulses and exposes the running seconds/minutes counts. It is the successor of the fixed 256-cycle timegen and sits between the clock input and the time/alarm counters. New behaviour over its predecessor: a correct modulo-N seconds wrap, run/pause gating, an hour tick, and count outputs for display and stopwatch use.

## Interface
Parameters:
- `CLK_PER_SEC`, 256: clk cycles per second tick; must be ≥ 2.
- `SEC_PER_MIN`, 60: seconds per minute wrap; must be ≥ 2.
- `MIN_PER_HOUR`, 60: minutes per hour wrap; must be ≥ 2.
- Derived widths (localparam): `PW = $clog2(CLK_PER_SEC)`, `SW = $clog2(SEC_PER_MIN)`, `MW = $clog2(MIN_PER_HOUR)`.

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `reset_count` input 1: synchronous, active-high clear of prescaler, counts and pulses.
- `run` input 1: 1 = time base advances, 0 = paused (all state held).
- `stop_watch` input 1: fast-set mode; `one_minute` pulses with every second.
- `one_second` output 1: one-cycle pulse per second.
- `one_minute` output 1: one-cycle pulse per minute (per second in `stop_watch`).
- `one_hour` output 1: one-cycle pulse per minute-counter wrap.
- `sec_count` output SW: current seconds, 0..SEC_PER_MIN-1.
- `min_count` output MW: current minutes, 0..MIN_PER_HOUR-1.

## Operation
- Prescaler P counts 0..CLK_PER_SEC-1 while `run`=1; it wraps to 0 at terminal. The wrap edge is the "second event".
- Second event: `sec_count` increments, or wraps from SEC_PER_MIN-1 to 0. `one_second`<=1.
- Minute event: occurs on a second event where `sec_count`==SEC_PER_MIN-1, or on every second event when `stop_watch`=1. `one_minute`<=1. `min_count` increments, or wraps from MIN_PER_HOUR-1 to 0.
- Hour event: occurs on a minute event where `min_count`==MIN_PER_HOUR-1. `one_hour`<=1.
- In `stop_watch` mode `sec_count` still advances and wraps normally.
- Priority, highest first: `reset`, then `reset_count`, then `run`=0, then normal counting.
- `reset` and `reset_count` have identical effect.
- `run`=0: P, `sec_count` and `min_count` hold; all pulse outputs are 0.
- `stop_watch` is sampled each cycle; a change takes effect at the next second event. There is no glitch and no extra pulse.
- Reset value of every output is 0. P is also 0 after reset.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Each pulse is high for exactly one cycle. With `run` held high, consecutive `one_second` pulses are exactly CLK_PER_SEC cycles apart.
- First `one_second` after reset release (`run`=1): asserted in the cycle after the CLK_PER_SEC-th rising edge with reset low.
- `sec_count`, `min_count` and the coincident pulses update on the same edge. `one_minute` and `one_hour` always coincide with `one_second`.
- Pause mid-second: the residual P is kept. Resume completes the remaining cycles, so no second is lost or shortened.
- `reset_count` asserted on the same edge as a second event: the clear wins and no pulse is emitted.
- Wraps are exact modulo-N. `sec_count` never reaches SEC_PER_MIN, including for non-power-of-2 parameters.

## Structure
- Shared package `aclk_pkg`: default constants `ACLK_CLK_PER_SEC`, `ACLK_SEC_PER_MIN`, `ACLK_MIN_PER_HOUR`; used by this block and the time/alarm counters.
- Sub-module `aclk_modcounter`: parameter N; inputs `clk`, `reset`, `clr`, `inc`; outputs `count` and `wrap`. `wrap` is combinational and equals `inc` && `count`==N-1.
- `aclk_modcounter` is instantiated three times: prescaler, seconds, minutes.
- Top level holds the event chaining and the registered pulse flops.
- Elaboration-time assertion that all parameters are ≥ 2.

## Test plan
- Defaults, `run`=1 for 256×61 cycles: `one_second` every 256 cycles. `sec_count` sequence is 0..59,0. `one_minute` occurs once, on the 59→0 wrap.
- CLK_PER_SEC=4, SEC_PER_MIN=3, MIN_PER_HOUR=2, `run`=1: `one_hour` asserts after 4×3×2=24 cycles, coincident with `one_minute` and `one_second`. Both counts are 0 afterward.
- Same params, `stop_watch`=1: `one_minute` pulses every 4 cycles. `min_count` toggles 0,1,0. `one_hour` occurs every 8 cycles.
- Pause: drop `run` after 2 cycles for 10 cycles, then resume. `one_second` arrives exactly 2 cycles after resume; no pulses occur while paused.
- `reset_count` pulse on the terminal-prescaler edge: no `one_second`, all counts 0. Next pulse follows CLK_PER_SEC cycles later.
- `reset` asserted mid-minute with `run`=1: all outputs are 0 on the following cycle. Counting restarts from P=0.
